// File: rtl/fir_decim_out_stage.sv
// rtl/fir_decim_out_stage.sv - decimate, shift-scale and FIFO-buffer FIR output samples
// Optional macro FIR_OUT_ROUND_EN: round half up when scaling instead of floor.
module fir_decim_out_stage #(
    parameter int DW        = 16,
    parameter int DECIM     = 4,
    parameter int OUT_SHIFT = 2,
    parameter int AW        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] data_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DW-1:0]        m_data,
    output logic [AW:0]          fifo_level,
    output logic                 overflow,
    input  logic                 clr_ovf
);
    localparam int              PW       = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int              DEPTH    = 1 << AW;
    localparam logic [PW-1:0]   PH_LAST  = PW'(DECIM - 1);
    localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] scaled;

`ifdef FIR_OUT_ROUND_EN
    localparam int          RS  = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic [DW:0] RND = (OUT_SHIFT > 0) ? ((DW+1)'(1) << RS) : '0;
    logic signed [DW:0] rnd_sum;
    // One guard bit keeps the +half from wrapping the most positive sample.
    assign rnd_sum = $signed({data_in[DW-1], data_in}) + $signed(RND);
    assign scaled  = DW'(rnd_sum >>> OUT_SHIFT);
`else
    assign scaled  = data_in >>> OUT_SHIFT;
`endif

    logic [PW-1:0] phase_q, phase_d;
    logic          s1_vld_q, s1_vld_d;
    logic [DW-1:0] s1_data_q, s1_data_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic keep, full, pop, push, drop;

    always_comb begin
        keep = in_valid && (phase_q == '0);
        full = (level_q == LVL_FULL);
        pop  = (level_q != '0) && m_ready;
        // A pop on the same edge frees the slot, so a full FIFO can still accept.
        push = s1_vld_q && (!full || pop);
        drop = s1_vld_q && full && !pop;

        phase_d = phase_q;
        if (in_valid) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
        end

        s1_vld_d  = keep;
        s1_data_d = keep ? scaled : s1_data_q;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW+1)'(1);
        end

        ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q   <= '0;
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end

    assign m_valid    = (level_q != '0);
    assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_fir_decim_out_stage.sv
// tb/tb_fir_decim_out_stage.sv - directed self-checking bench for fir_decim_out_stage
module tb_fir_decim_out_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] data_in;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        clr_ovf;

    int checks = 0;
    int errors = 0;

    fir_decim_out_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One kept sample followed by DECIM-1 discarded ones, leaving phase at 0.
    task automatic feed(input logic [15:0] raw);
        in_valid = 1'b1;
        data_in  = raw;
        step();
        for (int k = 0; k < 3; k++) begin
            data_in = 16'($urandom);
            step();
        end
        in_valid = 1'b0;
    endtask

    logic [15:0] exp_d [8];
    logic [15:0] exp_neg;
    logic [15:0] exp_q [8];
    logic        gap_v [7];

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        m_ready  = 1'b0;
        clr_ovf  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            data_in  = 16'($urandom);
            m_ready  = 1'($urandom);
            clr_ovf  = 1'($urandom);
            step();
        end
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 16'h0000);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);

        in_valid = 1'b0;
        m_ready  = 1'b0;
        clr_ovf  = 1'b0;
        rst      = 1'b1;
        step();

        // Decimate/scale: inputs 0x0100..0x0800, sink always ready.
        exp_d = '{16'h0000, 16'h0040, 16'h0000, 16'h0000,
                  16'h0000, 16'h0140, 16'h0000, 16'h0000};
        m_ready  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 16'((i + 1) << 8);
            step();
            check($sformatf("dec_valid_%0d", i), m_valid, (exp_d[i] != 16'h0));
            check($sformatf("dec_data_%0d", i), m_data, exp_d[i]);
        end
        in_valid = 1'b0;
        m_ready  = 1'b0;

        // Negative sample scaling.
`ifdef FIR_OUT_ROUND_EN
        exp_neg = 16'hFFFE;
`else
        exp_neg = 16'hFFFD;
`endif
        feed(16'hFFF6);
        check("neg_level", fifo_level, 1);
        check("neg_data", m_data, exp_neg);
        m_ready = 1'b1;
        step();
        check("neg_drained", m_valid, 0);
        m_ready = 1'b0;

        // Fill to full, then one more kept sample is dropped.
        for (int i = 1; i <= 8; i++) feed(16'(4 * i));
        check("full_level", fifo_level, 8);
        check("full_no_ovf", overflow, 0);
        feed(16'd36);
        check("ovf_level", fifo_level, 8);
        check("ovf_set", overflow, 1);
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_valid_%0d", i), m_valid, 1);
            check($sformatf("drain_data_%0d", i), m_data, i);
            step();
        end
        m_ready = 1'b0;
        check("drain_empty_valid", m_valid, 0);
        check("drain_empty_data", m_data, 0);
        check("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO with push and pop on the same edge.
        for (int i = 0; i < 8; i++) feed(16'(4 * (10 + i)));
        check("pp_pre_level", fifo_level, 8);
        in_valid = 1'b1;
        data_in  = 16'd396;
        step();
        data_in = 16'h0;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("pp_level", fifo_level, 8);
        check("pp_no_ovf", overflow, 0);
        check("pp_head", m_data, 11);
        step();
        step();
        in_valid = 1'b0;
        exp_q = '{16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd99};
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_out_%0d", i), m_data, exp_q[i]);
            step();
        end
        m_ready = 1'b0;
        check("pp_empty", m_valid, 0);
        check("pp_ovf_final", overflow, 0);

        // Asynchronous reset with data buffered.
        for (int i = 1; i <= 5; i++) feed(16'(4 * i));
        check("ar_pre_level", fifo_level, 5);
        #2 rst = 1'b0;
        #1;
        check("ar_level", fifo_level, 0);
        check("ar_valid", m_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // in_valid gaps: keep 1st and 5th valid inputs.
        gap_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int j = 0; j < 7; j++) begin
            in_valid = gap_v[j];
            data_in  = 16'(4 * (j + 1));
            step();
        end
        in_valid = 1'b0;
        step();
        check("gap_level", fifo_level, 2);
        check("gap_first", m_data, 1);
        m_ready = 1'b1;
        step();
        check("gap_second", m_data, 7);
        step();
        check("gap_empty", m_valid, 0);
        m_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
